// File: rtl/reg_access_ctrl.sv
// Register-bank initiator: takes one read/write request at a time, strobes the
// addressed register for a single cycle, samples the shared read/error lines
// and hands back exactly one response per request.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; address range checked on accept
// ACCESS | one-hot write or read strobe to the latched register
// SAMPLE | strobes off; capture read data and error from the bank
// RESP   | response held on rsp_* until the consumer takes it
module reg_access_ctrl #(
    parameter int NUM_BITS  = 16,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [NUM_BITS-1:0]  req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [NUM_BITS-1:0]  rsp_rdata,
    output logic                 rsp_error,
    output logic [NUM_BITS-1:0]  reg_write_data,
    output logic [NUM_REGS-1:0]  reg_write_enable,
    output logic [NUM_REGS-1:0]  reg_read_enable,
    input  logic [NUM_BITS-1:0]  reg_read_data,
    input  logic                 reg_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    // One extra bit so NUM_REGS == 2**ADDR_BITS is representable.
    localparam logic [ADDR_BITS:0] NUM_REGS_W = NUM_REGS[ADDR_BITS:0];
    localparam logic [NUM_REGS-1:0] ONE_HOT_0 = NUM_REGS'(1);

    state_t                state;
    state_t                state_nxt;
    logic                  write_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [NUM_BITS-1:0]   wdata_q;
    logic                  accept;
    logic                  addr_bad;

    assign accept   = req_valid && (state == IDLE);
    assign addr_bad = ({1'b0, req_addr} >= NUM_REGS_W);

    // State register; reset returns to IDLE so strobes drop at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: out-of-range addresses skip the bank and go straight to RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = addr_bad ? RESP : ACCESS;
            ACCESS:  state_nxt = SAMPLE;
            SAMPLE:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only, so at most one strobe is ever high
    // and only during ACCESS.
    always_comb begin
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        reg_write_enable = '0;
        reg_read_enable  = '0;
        reg_write_data   = '0;
        case (state)
            IDLE:   req_ready = 1'b1;
            ACCESS: begin
                if (write_q) begin
                    reg_write_enable = ONE_HOT_0 << addr_q;
                    reg_write_data   = wdata_q;
                end else begin
                    reg_read_enable  = ONE_HOT_0 << addr_q;
                end
            end
            RESP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch and response capture; bank inputs are only looked at in SAMPLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (accept) begin
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_error <= addr_bad;
        end else if (state == SAMPLE) begin
            rsp_rdata <= write_q ? '0 : reg_read_data;
            // A floating or unknown error line is treated as no error.
            rsp_error <= (reg_error === 1'b1);
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a small register-bank model that
// answers a strobe on the following cycle.
module tb_reg_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Main instance: 8 registers
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic [15:0] reg_write_data;
    logic [7:0]  reg_write_enable;
    logic [7:0]  reg_read_enable;
    wire  [15:0] reg_read_data;
    logic        reg_error;

    // Second instance: 6 registers, used for out-of-range addresses
    logic        req6_valid = 1'b0;
    logic        req6_ready;
    logic [2:0]  req6_addr = '0;
    logic        rsp6_valid;
    logic [15:0] rsp6_rdata;
    logic        rsp6_error;
    logic [15:0] reg6_write_data;
    logic [5:0]  reg6_write_enable;
    logic [5:0]  reg6_read_enable;

    int tests = 0;
    int fails = 0;
    int inv_viol = 0;
    int dut6_strobes = 0;

    // Bank model state
    logic [15:0] mem [8];
    logic        rd_drive = 1'b0;
    logic [15:0] rd_q = '0;
    logic        bank_err = 1'b0;
    logic        inject_err = 1'b0;

    always #5 clk = ~clk;

    reg_access_ctrl #(.NUM_BITS(16), .NUM_REGS(8), .ADDR_BITS(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .reg_write_data(reg_write_data), .reg_write_enable(reg_write_enable),
        .reg_read_enable(reg_read_enable), .reg_read_data(reg_read_data),
        .reg_error(reg_error)
    );

    reg_access_ctrl #(.NUM_BITS(16), .NUM_REGS(6), .ADDR_BITS(3)) dut6 (
        .clk(clk), .reset(reset),
        .req_valid(req6_valid), .req_ready(req6_ready), .req_write(1'b0),
        .req_addr(req6_addr), .req_wdata(16'h0000),
        .rsp_valid(rsp6_valid), .rsp_ready(1'b1),
        .rsp_rdata(rsp6_rdata), .rsp_error(rsp6_error),
        .reg_write_data(reg6_write_data), .reg_write_enable(reg6_write_enable),
        .reg_read_enable(reg6_read_enable), .reg_read_data(16'h0000),
        .reg_error(1'b0)
    );

    // Registers answer one cycle after their strobe; bus floats otherwise.
    assign reg_read_data = rd_drive ? rd_q : 16'hzzzz;
    assign reg_error     = bank_err;

    always @(posedge clk) begin
        rd_drive <= 1'b0;
        bank_err <= 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (reg_write_enable[i]) mem[i] <= reg_write_data;
            if (reg_read_enable[i]) begin
                rd_drive <= 1'b1;
                rd_q     <= mem[i];
            end
        end
        if (|(reg_write_enable | reg_read_enable)) bank_err <= inject_err;
    end

    // Strobe invariants watched throughout the run
    always @(negedge clk) begin
        if (!reset) begin
            if ((|reg_write_enable && |reg_read_enable) ||
                ($countones({reg_write_enable, reg_read_enable}) > 1))
                inv_viol++;
            if (|reg6_write_enable || |reg6_read_enable) dut6_strobes++;
        end
    end

    task automatic test_reset;
        #12;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if ({reg_write_enable, reg_read_enable, reg_write_data} !== 32'h0) begin fails++;
            $display("FAIL reset_bank_outputs got %h want 0", {reg_write_enable, reg_read_enable, reg_write_data}); end
        tests++; if ({rsp_rdata, rsp_error} !== 17'h0) begin fails++; $display("FAIL reset_rsp_regs got %h want 0", {rsp_rdata, rsp_error}); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL post_reset_handshake got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_write;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd3; req_wdata = 16'hA5A5; rsp_ready = 1'b0;
        @(negedge clk);  // cycle N+1
        req_valid = 1'b0;
        tests++; if (reg_write_enable !== 8'b0000_1000) begin fails++; $display("FAIL wr_strobe got %b want 00001000", reg_write_enable); end
        tests++; if (reg_write_data !== 16'hA5A5) begin fails++; $display("FAIL wr_data got %h want a5a5", reg_write_data); end
        tests++; if (reg_read_enable !== 8'h00) begin fails++; $display("FAIL wr_no_read got %b want 0", reg_read_enable); end
        tests++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL wr_access_hs got ready=%b valid=%b want 0/0", req_ready, rsp_valid); end
        @(negedge clk);  // cycle N+2
        tests++; if (reg_write_enable !== 8'h00 || reg_write_data !== 16'h0) begin fails++;
            $display("FAIL wr_strobe_one_cycle got %b/%h want 0/0", reg_write_enable, reg_write_data); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rsp_early got %b want 0", rsp_valid); end
        @(negedge clk);  // cycle N+3
        tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 16'h0) begin fails++;
            $display("FAIL wr_rsp got v=%b e=%b d=%h want 1/0/0000", rsp_valid, rsp_error, rsp_rdata); end
        tests++; if (mem[3] !== 16'hA5A5) begin fails++; $display("FAIL wr_bank_mem got %h want a5a5", mem[3]); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++;
            $display("FAIL wr_rsp_taken got v=%b r=%b want 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_read;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (reg_read_enable !== 8'b0000_1000 || reg_write_enable !== 8'h00) begin fails++;
            $display("FAIL rd_strobe got re=%b we=%b want 00001000/0", reg_read_enable, reg_write_enable); end
        @(negedge clk);
        tests++; if (reg_read_enable !== 8'h00) begin fails++; $display("FAIL rd_strobe_one_cycle got %b want 0", reg_read_enable); end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5A5 || rsp_error !== 1'b0) begin fails++;
            $display("FAIL rd_rsp got v=%b d=%h e=%b want 1/a5a5/0", rsp_valid, rsp_rdata, rsp_error); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Highest valid index of the 8-register instance
    task automatic test_top_addr;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd7; req_wdata = 16'h7E57;
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (reg_write_enable !== 8'b1000_0000) begin fails++; $display("FAIL top_addr_strobe got %b want 10000000", reg_write_enable); end
        @(negedge clk); @(negedge clk);
        tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin fails++;
            $display("FAIL top_addr_rsp got v=%b e=%b want 1/0", rsp_valid, rsp_error); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Addresses 6 and 7 are out of range on the 6-register instance
    task automatic test_bad_addr;
        logic [2:0] bad [2];
        bad[0] = 3'd6; bad[1] = 3'd7;
        for (int k = 0; k < 2; k++) begin
            req6_valid = 1'b1; req6_addr = bad[k];
            @(negedge clk);  // cycle N+1
            req6_valid = 1'b0;
            tests++; if (rsp6_valid !== 1'b1 || rsp6_error !== 1'b1 || rsp6_rdata !== 16'h0) begin fails++;
                $display("FAIL bad_addr_%0d_rsp got v=%b e=%b d=%h want 1/1/0000", bad[k], rsp6_valid, rsp6_error, rsp6_rdata); end
            @(negedge clk);  // response taken (rsp_ready tied high)
            tests++; if (rsp6_valid !== 1'b0 || req6_ready !== 1'b1) begin fails++;
                $display("FAIL bad_addr_%0d_done got v=%b r=%b want 0/1", bad[k], rsp6_valid, req6_ready); end
        end
        // Address 5 is the last valid one and must strobe
        req6_valid = 1'b1; req6_addr = 3'd5;
        @(negedge clk);
        req6_valid = 1'b0;
        tests++; if (reg6_read_enable !== 6'b10_0000) begin fails++; $display("FAIL dut6_addr5_strobe got %b want 100000", reg6_read_enable); end
        @(negedge clk); @(negedge clk); @(negedge clk);
        tests++; if (dut6_strobes !== 1) begin fails++; $display("FAIL bad_addr_strobe_count got %0d want 1", dut6_strobes); end
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3; rsp_ready = 1'b0;
        @(negedge clk);
        // second request presented immediately and held
        req_write = 1'b1; req_addr = 3'd1; req_wdata = 16'h1234;
        @(negedge clk); @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5A5 || rsp_error !== 1'b0) begin fails++;
                $display("FAIL hold_rsp_c%0d got v=%b d=%h e=%b want 1/a5a5/0", c, rsp_valid, rsp_rdata, rsp_error); end
            tests++; if (req_ready !== 1'b0 || reg_write_enable !== 8'h00) begin fails++;
                $display("FAIL hold_no_accept_c%0d got r=%b we=%b want 0/0", c, req_ready, reg_write_enable); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++;
            $display("FAIL hold_released got v=%b r=%b want 0/1", rsp_valid, req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (reg_write_enable !== 8'b0000_0010 || reg_write_data !== 16'h1234) begin fails++;
            $display("FAIL second_req_strobe got %b/%h want 00000010/1234", reg_write_enable, reg_write_data); end
        @(negedge clk); @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++; if (mem[1] !== 16'h1234) begin fails++; $display("FAIL second_req_mem got %h want 1234", mem[1]); end
    endtask

    task automatic test_reg_error;
        inject_err = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        inject_err = 1'b0;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 16'h1234) begin fails++;
            $display("FAIL reg_error_rsp got v=%b e=%b d=%h want 1/1/1234", rsp_valid, rsp_error, rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_resp;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 reset = 1'b1;
        #1;
        tests++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_error !== 1'b0) begin fails++;
            $display("FAIL reset_in_resp got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_error); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL reset_in_resp_after got r=%b v=%b want 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_access;
        int rsp_seen;
        rsp_seen = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (reg_read_enable !== 8'b0001_0000) begin fails++; $display("FAIL rst_acc_strobe got %b want 00010000", reg_read_enable); end
        #1 reset = 1'b1;
        #1;
        tests++; if (reg_read_enable !== 8'h00 || reg_write_enable !== 8'h00) begin fails++;
            $display("FAIL rst_acc_drop got re=%b we=%b want 0/0", reg_read_enable, reg_write_enable); end
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        rsp_ready = 1'b0;
        tests++; if (rsp_seen !== 0) begin fails++; $display("FAIL rst_acc_no_rsp got %0d responses want 0", rsp_seen); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_top_addr();
        test_bad_addr();
        test_back_to_back();
        test_reg_error();
        test_reset_resp();
        test_reset_access();
        tests++; if (inv_viol !== 0) begin fails++; $display("FAIL strobe_invariant got %0d violations want 0", inv_viol); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
